// File: rtl/io_pkg.sv
// io_pkg: shared IO page addresses, STATUS bit positions and 7-segment font
package io_pkg;

    localparam logic [7:0] IO_LED     = 8'h00;
    localparam logic [7:0] IO_STATUS  = 8'h04;
    localparam logic [7:0] IO_SEGDATA = 8'h08;
    localparam logic [7:0] IO_INDATA  = 8'h10;
    localparam logic [7:0] IO_SWRAW   = 8'h14;

    localparam int ST_VLD  = 0;
    localparam int ST_OVF  = 1;
    localparam int ST_BUSY = 2;

    // Active-low segments {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: button synchroniser and debouncer with a one-cycle press pulse
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic btn_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          btn_stable;
    logic [CW-1:0] cnt;
    logic          done;

    assign done = (sync[1] != btn_stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) sync <= '0;
        else       sync <= {sync[0], btn};

    // Accept a new level only after it has held for DEBOUNCE_CYCLES; any bounce restarts
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cnt        <= '0;
            btn_stable <= 1'b0;
            btn_rise   <= 1'b0;
        end else begin
            cnt        <= (sync[1] == btn_stable || done) ? '0 : cnt + CW'(1);
            btn_stable <= done ? sync[1] : btn_stable;
            btn_rise   <= done && sync[1];
        end

endmodule

// File: rtl/io_periph_ctrl.sv
// io_periph_ctrl: IO page registers, switch capture and multiplexed hex display
module io_periph_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_DIV        = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int SW_ = $clog2(SCAN_DIV + 1);

    logic [7:0]     waddr;
    logic [15:0]    sw_meta, sw_sync;
    logic           cap;
    logic [15:0]    in_data;
    logic           in_vld, in_ovf;
    logic [31:0]    segdata;
    logic           seg_busy;
    logic [2:0]     digit;
    logic [SW_-1:0] scan;
    logic           we_seg, rd_in, scan_end;

    assign waddr    = io_addr & 8'hFC;
    assign we_seg   = io_we && waddr == IO_SEGDATA;
    assign rd_in    = io_rd && waddr == IO_INDATA;
    assign scan_end = scan == SW_'(SCAN_DIV - 1);

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk      (clk),
        .rstn     (rstn),
        .btn      (btn),
        .btn_rise (cap)
    );

    // Two-flop synchroniser for the switch bank
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) {sw_sync, sw_meta} <= '0;
        else       {sw_sync, sw_meta} <= {sw_meta, sw};

    // CPU-writable LED and display data registers
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            led     <= '0;
            segdata <= '0;
        end else begin
            led     <= (io_we && waddr == IO_LED) ? io_dout[15:0] : led;
            segdata <= we_seg ? io_dout : segdata;
        end

    // Capture wins over a same-edge INDATA read; overrun only when unread data is overwritten
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            in_data <= '0;
            in_vld  <= 1'b0;
            in_ovf  <= 1'b0;
        end else begin
            in_data <= cap ? sw_sync : in_data;
            in_vld  <= cap || (in_vld && !rd_in);
            in_ovf  <= cap ? (in_ovf || in_vld) && !rd_in : in_ovf && !rd_in;
        end

    // Digit scan; a SEGDATA write restarts the frame and busy lasts one full frame
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            scan     <= '0;
            digit    <= '0;
            seg_busy <= 1'b0;
        end else begin
            scan     <= (we_seg || scan_end) ? '0 : scan + SW_'(1);
            digit    <= we_seg ? 3'd0 : scan_end ? digit + 3'd1 : digit;
            seg_busy <= we_seg || (seg_busy && !(scan_end && digit == 3'd7));
        end

    assign an  = ~(8'b1 << digit);
    assign seg = hex7(segdata[{digit, 2'b00} +: 4]);

    assign io_din = (waddr == IO_LED)     ? {16'b0, led} :
                    (waddr == IO_STATUS)  ? {29'b0, seg_busy, in_ovf, in_vld} :
                    (waddr == IO_SEGDATA) ? segdata :
                    (waddr == IO_INDATA)  ? {16'b0, in_data} :
                    (waddr == IO_SWRAW)   ? {16'b0, sw_sync} : 32'b0;

endmodule

// File: tb/tb_io_periph_ctrl.sv
// tb_io_periph_ctrl: scoreboard-driven bench for the IO peripheral controller
module tb_io_periph_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  io_addr = '0;
    logic [31:0] io_dout = '0;
    logic        io_we = 1'b0;
    logic        io_rd = 1'b0;
    logic [31:0] io_din;
    logic [15:0] sw = '0;
    logic        btn = 1'b0;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] cap_q[$];
    logic [14:0] disp_q[$];
    logic        m_vld = 1'b0;
    logic        m_ovf = 1'b0;

    // Active-high font, inverted when building expectations
    logic [6:0] font_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    io_periph_ctrl #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(3)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .io_we   (io_we),
        .io_rd   (io_rd),
        .io_din  (io_din),
        .sw      (sw),
        .btn     (btn),
        .led     (led),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        io_addr = a;
        #1;
        v = io_din;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_addr = a;
        io_dout = d;
        io_we   = 1'b1;
        tick;
        io_we   = 1'b0;
    endtask

    task automatic press(input logic [15:0] v, input bit rd_cap);
        logic [31:0] r;
        sw = v;
        tick;
        tick;
        btn = 1'b1;
        repeat (6) tick;
        rd(8'h04, r);
        n_cmp++;
        if (r[0] !== m_vld) begin
            n_err++;
            $display("FAIL pre_cap_vld: got %0b want %0b", r[0], m_vld);
        end
        if (rd_cap) begin
            io_rd = 1'b1;
            rd(8'h10, r);
            n_cmp++;
            if (cap_q.size() == 0 || r !== {16'b0, cap_q[0]}) begin
                n_err++;
                $display("FAIL same_edge_read: got %h want %h", r, cap_q.size() ? {16'b0, cap_q[0]} : 32'hx);
            end
            if (cap_q.size() != 0) void'(cap_q.pop_front());
        end
        tick;
        io_rd = 1'b0;
        if (rd_cap) m_ovf = 1'b0;
        else if (m_vld) begin
            m_ovf = 1'b1;
            if (cap_q.size() != 0) void'(cap_q.pop_front());
        end
        m_vld = 1'b1;
        cap_q.push_back(v);
        rd(8'h04, r);
        n_cmp++;
        if (r !== {30'b0, m_ovf, m_vld}) begin
            n_err++;
            $display("FAIL post_cap_status: got %h want %h", r, {30'b0, m_ovf, m_vld});
        end
        repeat (3) tick;
        btn = 1'b0;
        repeat (10) tick;
    endtask

    task automatic read_indata(input string nm);
        logic [31:0] r;
        io_rd = 1'b1;
        rd(8'h10, r);
        n_cmp++;
        if (cap_q.size() == 0 || r !== {16'b0, cap_q[0]}) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, r, cap_q.size() ? {16'b0, cap_q[0]} : 32'hx);
        end
        if (cap_q.size() != 0) void'(cap_q.pop_front());
        tick;
        io_rd = 1'b0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        rd(8'h04, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_err++;
            $display("FAIL %s_clear: status got %h want 0", nm, r);
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        logic [7:0]  addrs [4] = '{8'h00, 8'h04, 8'h08, 8'h10};
        repeat (3) tick;
        rstn = 1'b1;
        n_cmp++;
        if (an !== 8'hFE || seg !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_display: an=%h seg=%b want FE 1000000", an, seg);
        end
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], r);
            n_cmp++;
            if (r !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read_%h: got %h want 0", addrs[i], r);
            end
        end
    endtask

    task automatic test_led;
        logic [31:0] r;
        wr(8'h00, 32'h0000A5A5);
        rd(8'h00, r);
        n_cmp++;
        if (led !== 16'hA5A5 || r !== 32'h0000A5A5) begin
            n_err++;
            $display("FAIL led_write: led=%h read=%h want A5A5", led, r);
        end
        wr(8'h0C, 32'hFFFFFFFF);
        rd(8'h08, r);
        n_cmp++;
        if (led !== 16'hA5A5 || r !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_write: led=%h segdata=%h want A5A5 0", led, r);
        end
        rd(8'h0C, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_read: got %h want 0", r);
        end
    endtask

    task automatic test_capture;
        logic [31:0] r;
        press(16'h1234, 1'b0);
        rd(8'h14, r);
        n_cmp++;
        if (r !== 32'h00001234) begin
            n_err++;
            $display("FAIL swraw: got %h want 00001234", r);
        end
        read_indata("indata_1234");
    endtask

    task automatic test_bounce;
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1;
            tick;
            tick;
            btn = 1'b0;
            tick;
            tick;
        end
        for (int i = 0; i < 12; i++) begin
            rd(8'h04, r);
            n_cmp++;
            if (r[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_no_capture: cycle %0d vld=%0b want 0", i, r[0]);
            end
            tick;
        end
    endtask

    task automatic test_overrun;
        logic [31:0] r;
        press(16'h0001, 1'b0);
        press(16'h0002, 1'b0);
        rd(8'h04, r);
        n_cmp++;
        if (r !== 32'h3) begin
            n_err++;
            $display("FAIL overrun_status: got %h want 3", r);
        end
        read_indata("overrun_data");
        press(16'h0003, 1'b0);
        press(16'h0004, 1'b1);
        rd(8'h04, r);
        n_cmp++;
        if (r !== 32'h1) begin
            n_err++;
            $display("FAIL capture_wins_status: got %h want 1", r);
        end
        read_indata("capture_wins_data");
    endtask

    task automatic test_display;
        logic [31:0] r;
        logic [31:0] val = 32'h89ABCDEF;
        wr(8'h08, val);
        for (int d = 0; d < 8; d++)
            repeat (3) disp_q.push_back({~(8'b1 << d), ~font_hi[val[4*d +: 4]]});
        for (int i = 0; i < 24; i++) begin
            rd(8'h04, r);
            n_cmp++;
            if (r[2] !== 1'b1) begin
                n_err++;
                $display("FAIL seg_busy_set: cycle %0d got %0b want 1", i, r[2]);
            end
            n_cmp++;
            if (disp_q.size() == 0 || {an, seg} !== disp_q[0]) begin
                n_err++;
                $display("FAIL scan: cycle %0d an=%h seg=%b want %h", i, an, seg, disp_q.size() ? disp_q[0] : 15'hx);
            end
            if (disp_q.size() != 0) void'(disp_q.pop_front());
            tick;
        end
        rd(8'h04, r);
        n_cmp++;
        if (r[2] !== 1'b0 || an !== 8'hFE || seg !== 7'b0001110) begin
            n_err++;
            $display("FAIL frame_end: busy=%0b an=%h seg=%b want 0 FE 0001110", r[2], an, seg);
        end
        rd(8'h08, r);
        n_cmp++;
        if (r !== val) begin
            n_err++;
            $display("FAIL segdata_read: got %h want %h", r, val);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] r;
        sw = 16'h5555;
        tick;
        tick;
        btn = 1'b1;
        repeat (4) tick;
        rstn = 1'b0;
        btn  = 1'b0;
        tick;
        rstn = 1'b1;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        cap_q.delete();
        repeat (10) tick;
        rd(8'h04, r);
        n_cmp++;
        if (r !== 32'h0) begin
            n_err++;
            $display("FAIL abort_status: got %h want 0", r);
        end
        rd(8'h10, r);
        n_cmp++;
        if (r !== 32'h0 || led !== 16'h0) begin
            n_err++;
            $display("FAIL abort_data: indata=%h led=%h want 0 0", r, led);
        end
    endtask

    initial begin
        test_reset;
        test_led;
        test_capture;
        test_bounce;
        test_overrun;
        test_display;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
